// File: rtl/regfile_writer.sv
// Regfile write-port arbiter: in-order ALU results take priority over a one-entry
// mul/div result buffer, with an age-driven stall hint and a pending-write scoreboard.
module regfile_writer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        alu_valid,
  input  logic [4:0]  alu_dst,
  input  logic [31:0] alu_data,
  input  logic        alu_overflow,
  input  logic        md_valid,
  output logic        md_ready,
  input  logic [4:0]  md_dst,
  input  logic [31:0] md_data,
  input  logic        md_issue,
  input  logic [4:0]  md_issue_dst,
  output logic        wr,
  output logic [4:0]  RegWrDst_W,
  output logic [31:0] wd,
  output logic        if_overflow,
  output logic        stall_req,
  output logic [31:0] busy
);

  localparam int unsigned RegW  = 5;
  localparam int unsigned DataW = 32;
  localparam int unsigned NumRegs = 32;
  localparam int unsigned AgeW  = 2;

  logic              buf_valid_q, buf_valid_d;
  logic [RegW-1:0]   buf_dst_q, buf_dst_d;
  logic [DataW-1:0]  buf_data_q, buf_data_d;
  logic [AgeW-1:0]   age_q, age_d;
  logic              stall_q, stall_d;
  logic [NumRegs-1:0] busy_q, busy_d;
  logic              wr_q, wr_d;
  logic [RegW-1:0]   dst_q, dst_d;
  logic [DataW-1:0]  wd_q, wd_d;
  logic              ovf_q, ovf_d;

  logic alu_take, drain, accept;

  // Ready depends only on buffer state, so a freed entry cannot refill in its drain cycle.
  assign md_ready = !buf_valid_q;

  always_comb begin
    buf_valid_d = buf_valid_q;
    buf_dst_d   = buf_dst_q;
    buf_data_d  = buf_data_q;
    age_d       = age_q;
    busy_d      = busy_q;
    wr_d        = 1'b0;
    dst_d       = RegW'(0);
    wd_d        = DataW'(0);
    ovf_d       = 1'b0;

    alu_take = alu_valid && (alu_dst != RegW'(0));
    drain    = buf_valid_q && !alu_take;
    accept   = md_valid && !buf_valid_q;

    if (alu_take) begin
      wr_d  = !alu_overflow;
      dst_d = alu_overflow ? RegW'(0) : alu_dst;
      wd_d  = alu_data;
      ovf_d = alu_overflow;
    end else if (drain) begin
      wr_d  = 1'b1;
      dst_d = buf_dst_q;
      wd_d  = buf_data_q;
    end

    if (drain) begin
      buf_valid_d        = 1'b0;
      age_d              = AgeW'(0);
      busy_d[buf_dst_q]  = 1'b0;
    end else if (buf_valid_q && (age_q != AgeW'(3))) begin
      age_d = age_q + AgeW'(1);
    end

    // Results for r0 are consumed here and never occupy the buffer.
    if (accept) begin
      buf_valid_d = (md_dst != RegW'(0));
      buf_dst_d   = md_dst;
      buf_data_d  = md_data;
      age_d       = AgeW'(0);
    end

    if (md_issue) begin
      busy_d[md_issue_dst] = 1'b1;
    end
    busy_d[0] = 1'b0;

    stall_d = buf_valid_d && (age_d >= AgeW'(2));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_valid_q <= 1'b0;
      buf_dst_q   <= RegW'(0);
      buf_data_q  <= DataW'(0);
      age_q       <= AgeW'(0);
      stall_q     <= 1'b0;
      busy_q      <= NumRegs'(0);
      wr_q        <= 1'b0;
      dst_q       <= RegW'(0);
      wd_q        <= DataW'(0);
      ovf_q       <= 1'b0;
    end else begin
      buf_valid_q <= buf_valid_d;
      buf_dst_q   <= buf_dst_d;
      buf_data_q  <= buf_data_d;
      age_q       <= age_d;
      stall_q     <= stall_d;
      busy_q      <= busy_d;
      wr_q        <= wr_d;
      dst_q       <= dst_d;
      wd_q        <= wd_d;
      ovf_q       <= ovf_d;
    end
  end

  assign wr          = wr_q;
  assign RegWrDst_W  = dst_q;
  assign wd          = wd_q;
  assign if_overflow = ovf_q;
  assign stall_req   = stall_q;
  assign busy        = busy_q;

endmodule
